rx_packet: RTL and testbench
============================

# rx_packet

UART receiver and packet assembler that feeds the 64-bit transmit stage and AES datapath. It deserialises 8N1 bytes from the RS-232 line and packs eight of them, LSB byte first, into one 64-bit block. It then presents the block with a single-cycle valid strobe. It sits between the board RX pin and the block-level logic that consumes 64-bit `data_in` words.

## Interface
- `CLKS_PER_BIT`, default 5208: clk cycles per UART bit (50 MHz / 9600 baud).
- `NUM_BYTES`, default 8: bytes per packet; output width is `8*NUM_BYTES`.
- `TIMEOUT_BITS`, default 40: idle bit-times after which a partial packet is discarded.
- `clk`  in  1  sole clock; everything is on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_in`  in  1  asynchronous serial line, idle high.
- `data_out`  out  64  last complete packet; byte k is at `[8k+7:8k]`.
- `rx_valid`  out  1  one-cycle pulse when `data_out` has just been updated.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit or a false start.
- `busy`  out  1  high while a packet is partially received (byte index ≠ 0 or FSM ≠ IDLE).

## Operation
- `rx_in` passes through a 2-FF synchroniser, giving `rx_s`. All decisions use `rx_s`.
- Bit counter `cnt` runs 0..CLKS_PER_BIT-1. The bit index is 0..7 and the byte index `bidx` is 0..NUM_BYTES-1.
- FSM states and transitions:
  - IDLE: a falling `rx_s` (1 → 0) moves to START with `cnt=0`.
  - START: at `cnt==CLKS_PER_BIT/2-1` (mid start bit), sample `rx_s`.
    - If the sample is 0, go to DATA with `cnt=0`.
    - If the sample is 1, it is a false start: pulse `frame_err`, clear `bidx`, go to IDLE.
  - DATA: at `cnt==CLKS_PER_BIT-1`, sample `rx_s` into shift bit `[bit]`, LSB first. After bit 7, go to STOP.
  - STOP: at `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
    - If the sample is 1, write the byte into the staging register at `bidx`.
      - If `bidx==NUM_BYTES-1`: copy the staging register to `data_out`, pulse `rx_valid`, set `bidx=0`.
      - Otherwise `bidx++`.
      - Go to IDLE.
    - If the sample is 0: pulse `frame_err`, set `bidx=0` to discard the packet, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s==1`, then go to IDLE. This prevents a break condition from re-triggering.
- Inter-byte timeout: in IDLE with `bidx≠0`, an idle counter runs. When it reaches `TIMEOUT_BITS*CLKS_PER_BIT`, set `bidx=0` with no error pulse. The counter clears on any falling edge and whenever `bidx==0`.
- `data_out` changes only on packet completion and otherwise holds its value, so a downstream transmit stage may sample it at any time after `rx_valid`.

## Timing
- Reset values:
  - `data_out=0`, `rx_valid=0`, `frame_err=0`, `busy=0`.
  - FSM=IDLE, `bidx=0`, `cnt=0`, staging register = 0.
  - Synchroniser flops = 1.
- `rst` mid-frame aborts immediately and discards the partial packet. No pulse is emitted.
- Latency from the line edge to FSM reaction is 2 cycles (synchroniser).
- `rx_valid` and `frame_err` are registered and assert the cycle after the stop-bit sample. They are never high together.
- Data bits are sampled at 1.5, 2.5 … bit-times after the start edge (plus 2 cycles); the stop bit is sampled at 9.5 bit-times. The FSM is back in IDLE about 0.5 bit before the stop bit ends, so back-to-back bytes with zero idle time are accepted.
- A falling edge that coincides with the timeout expiry starts a new byte with `bidx=0`.
- Arithmetic: `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. The idle counter is wide enough for `TIMEOUT_BITS*CLKS_PER_BIT` with no wrap.

## Structure
- Shared package `rs232_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - `CLKS_PER_BIT_9600_50M = 5208`;
  - `PKT_BYTES = 8`.
  - The transmit stage uses the same constants.
- One natural sub-module: `uart_rx_byte`, which contains the synchroniser, START/DATA/STOP/WAIT_HIGH FSM and produces `byte`, `byte_valid` and `byte_err`.
- The top level holds `bidx`, the staging register, the timeout counter and `data_out`.

## Test plan
- Send bytes 0x01,0x23,0x45,0x67,0x89,0xAB,0xCD,0xEF at 9600 baud with 1 idle bit between them → a single `rx_valid` pulse with `data_out=64'hEFCDAB8967452301`, and `busy` falls the same cycle.
- Send the same 8 bytes with zero inter-byte gap, then a second packet of 0xFF×8 → two `rx_valid` pulses, with `data_out=64'hFFFFFFFFFFFFFFFF` after the second.
- Send 3 bytes, wait 50 bit-times, then send 8 bytes 0x11..0x88 → exactly one `rx_valid` with `data_out=64'h8877665544332211`.
- Send byte 0x55 with stop bit forced 0 at byte 4 → `frame_err` pulses once, no `rx_valid`. A following clean 8-byte packet is received correctly.
- Apply a 0.3-bit low glitch on an idle line → `frame_err` pulses, `bidx` stays 0, `data_out` is unchanged.
- Assert `rst` for 1 cycle during bit 5 of byte 2 → all outputs return to their reset values. The next full packet is received with the correct byte order.

Source files
------------

// File: rtl/rs232_pkg.sv
// Constants and FSM encoding shared by the RS-232 receive and transmit stages.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int CLKS_PER_BIT_9600_50M = 5208;
  localparam int PKT_BYTES             = 8;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: line synchroniser plus START/DATA/STOP/WAIT_HIGH sequencer.
// Strobes are decoded from the sample cycle so the packet layer can register them directly.
module uart_rx_byte
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_50M
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       start_edge,
  output logic       rx_active
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;

  assign start_edge = (state == IDLE) && rx_d && !rx_s;
  assign byte_valid = (state == STOP) && (cnt == CNT_LAST) && rx_s;
  assign byte_err   = ((state == START) && (cnt == CNT_MID) && rx_s) ||
                      ((state == STOP) && (cnt == CNT_LAST) && !rx_s);
  assign rx_active  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (start_edge) state <= START;
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must return high before a new start is armed.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == DATA) && (cnt == CNT_LAST)) rx_byte[bit_idx] <= rx_s;
  end

endmodule

// File: rtl/rx_packet.sv
// Packs NUM_BYTES received UART bytes, LSB byte first, into one block with a valid strobe.
// Partial packets are dropped on a framing error or an inter-byte idle timeout.
module rx_packet
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_50M,
  parameter int NUM_BYTES    = PKT_BYTES,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  output logic [8*NUM_BYTES-1:0] data_out,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int BIDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(NUM_BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_LIMIT - 1);

  logic [7:0]             rx_byte;
  logic                   byte_valid;
  logic                   byte_err;
  logic                   start_edge;
  logic                   rx_active;
  logic [BIDX_W-1:0]      bidx;
  logic [8*NUM_BYTES-1:0] stage;
  logic [8*NUM_BYTES-1:0] stage_nxt;
  logic [TMO_W-1:0]       idle_cnt;
  logic                   tmo_run;
  logic                   tmo_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .start_edge(start_edge),
    .rx_active (rx_active)
  );

  always_comb begin
    stage_nxt = stage;
    stage_nxt[8*bidx +: 8] = rx_byte;
  end

  assign tmo_run = !rx_active && (bidx != '0);
  assign tmo_hit = tmo_run && (idle_cnt == TMO_LAST);
  assign busy    = rx_active || (bidx != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      bidx      <= '0;
      stage     <= '0;
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tmo_run && !start_edge && !tmo_hit) idle_cnt <= idle_cnt + 1'b1;
      else                                    idle_cnt <= '0;
      if (byte_valid) begin
        stage <= stage_nxt;
        if (bidx == BIDX_LAST) begin
          data_out <= stage_nxt;
          rx_valid <= 1'b1;
          bidx     <= '0;
        end else begin
          bidx <= bidx + 1'b1;
        end
      end else if (byte_err) begin
        frame_err <= 1'b1;
        bidx      <= '0;
      end else if (tmo_hit) begin
        // Expiry wins over a coincident start edge, so that byte lands at index 0.
        bidx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_packet.sv
// Bench for rx_packet: scenario table, hand-written glitch/reset sequences, random byte stream.
module tb_rx_packet;

  localparam int CPB = 16;
  localparam int NB  = 8;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic [63:0]   data_out;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;

  rx_packet #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB),
    .TIMEOUT_BITS(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbytes;
    logic [63:0] bytes;
    int          bad_idx;
    int          gap;
    int          post_idle;
    int          exp_valid;
    logic [63:0] exp_data;
    int          exp_err;
    logic        exp_busy;
  } row_t;

  row_t        rows[7];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] got_q[$];
  int          err_cnt = 0;
  int          busy_viol = 0;
  int          both_viol = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        got_q.push_back(data_out);
        if (busy) busy_viol++;
      end
      if (frame_err) err_cnt++;
      if (rx_valid && frame_err) both_viol++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_ok);
    rx_in = 1'b1;
  endtask

  int          v0;
  int          e0;
  int          start_idx;
  int          gap;
  logic [63:0] d0;
  logic [63:0] pkt;
  logic [7:0]  rb;
  logic        bad;
  logic [7:0]  model_q[$];
  logic [63:0] exp_q[$];
  int          exp_err;

  initial begin
    rows[0] = '{8, 64'hEFCDAB8967452301, -1, 1, 0,  1, 64'hEFCDAB8967452301, 0, 1'b0};
    rows[1] = '{8, 64'hEFCDAB8967452301, -1, 0, 0,  1, 64'hEFCDAB8967452301, 0, 1'b0};
    rows[2] = '{8, 64'hFFFFFFFFFFFFFFFF, -1, 0, 0,  1, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0};
    rows[3] = '{3, 64'h0000000000A3A2A1, -1, 1, 50, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1'b1};
    rows[4] = '{8, 64'h8877665544332211, -1, 1, 0,  1, 64'h8877665544332211, 0, 1'b0};
    rows[5] = '{5, 64'h00000055C0DEFACE,  4, 1, 0,  0, 64'h8877665544332211, 1, 1'b0};
    rows[6] = '{8, 64'h0123456789ABCDEF, -1, 1, 0,  1, 64'h0123456789ABCDEF, 0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 64'h0);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    idle_bits(2);

    foreach (rows[r]) begin
      v0 = got_q.size();
      e0 = err_cnt;
      for (int i = 0; i < rows[r].nbytes; i++) begin
        send_byte(rows[r].bytes[8*i +: 8], i != rows[r].bad_idx);
        idle_bits(rows[r].gap);
      end
      check($sformatf("row%0d_valid_count", r), got_q.size() - v0, rows[r].exp_valid);
      check($sformatf("row%0d_data_out", r), data_out, rows[r].exp_data);
      check($sformatf("row%0d_frame_err_count", r), err_cnt - e0, rows[r].exp_err);
      check($sformatf("row%0d_busy", r), busy, rows[r].exp_busy);
      if (rows[r].post_idle > 0) begin
        idle_bits(rows[r].post_idle);
        check($sformatf("row%0d_busy_after_timeout", r), busy, 1'b0);
      end
    end

    // False start: 5-cycle low pulse, shorter than half a bit
    d0 = data_out;
    e0 = err_cnt;
    v0 = got_q.size();
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    idle_bits(2);
    check("glitch_frame_err", err_cnt - e0, 1);
    check("glitch_no_valid", got_q.size() - v0, 0);
    check("glitch_data_out", data_out, d0);
    check("glitch_busy", busy, 1'b0);

    // Reset during bit 5 of the third byte (0xE5: bits 5..7 and stop are high)
    send_byte(8'h3C, 1'b1);
    idle_bits(1);
    send_byte(8'hA5, 1'b1);
    idle_bits(1);
    rb = 8'hE5;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(rb[i]);
    rx_in = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    e0 = err_cnt;
    v0 = got_q.size();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data_out", data_out, 64'h0);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    idle_bits(5);
    check("midrst_no_pulse_err", err_cnt - e0, 0);
    check("midrst_no_pulse_valid", got_q.size() - v0, 0);
    pkt = 64'h0F1E2D3C4B5A6978;
    for (int i = 0; i < 8; i++) begin
      send_byte(pkt[8*i +: 8], 1'b1);
      idle_bits(1);
    end
    check("midrst_next_valid_count", got_q.size() - v0, 1);
    check("midrst_next_data_out", data_out, pkt);

    // Random byte stream against a byte-list packet model
    start_idx = got_q.size();
    e0 = err_cnt;
    exp_err = 0;
    model_q.delete();
    exp_q.delete();
    for (int n = 0; n < 60; n++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      send_byte(rb, !bad);
      if (bad) begin
        exp_err++;
        model_q.delete();
      end else begin
        model_q.push_back(rb);
        if (model_q.size() == NB) begin
          for (int k = 0; k < NB; k++) pkt[8*k +: 8] = model_q[k];
          exp_q.push_back(pkt);
          model_q.delete();
        end
      end
      case ($urandom_range(0, 15))
        0:       gap = TMO + 5;
        1, 2, 3: gap = 0;
        default: gap = $urandom_range(1, 3);
      endcase
      if (bad && gap == 0) gap = 1;
      if (gap >= TMO) model_q.delete();
      idle_bits(gap);
    end
    idle_bits(2);
    check("rand_packet_count", got_q.size() - start_idx, exp_q.size());
    check("rand_frame_err_count", err_cnt - e0, exp_err);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start_idx + i < got_q.size())
        check($sformatf("rand_packet%0d", i), got_q[start_idx + i], exp_q[i]);
    end

    check("busy_low_at_rx_valid", busy_viol, 0);
    check("valid_err_exclusive", both_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
